// File: rtl/sender_pkg.sv
// Shared types and constants for the serial frame sender.
// Frame length depends on whether the even-parity bit is appended.
package sender_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    localparam logic START_BIT  = 1'b1;
    localparam logic IDLE_LEVEL = 1'b0;

    function automatic int unsigned frame_bits(input int unsigned data_w, input bit parity);
        return parity ? data_w + 2 : data_w + 1;
    endfunction

endpackage

// File: rtl/serial_frame_sender_if.sv
// Host-side word handshake plus serial-line status for serial_frame_sender.
// The host drives through master; the sender sits on slave.
interface serial_frame_sender_if #(
    parameter int unsigned DATA_W = 40
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              sout;
    logic              busy;
    logic              frame_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, sout, busy, frame_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sout, busy, frame_done
    );
endinterface

// File: rtl/sender_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata_o shows the head word whenever non-empty.
// Pushes while full are dropped, pops while empty are ignored.
module sender_fifo #(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read of meaningful data.
    always_ff @(posedge clk_i) begin
        if (rst_ni && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/serial_frame_sender.sv
// Serial frame transmitter: FIFO-buffered words sent as start bit + payload [+ parity] + gap.
// Define SENDER_PARITY_EN to append an even-parity bit after the payload.
module serial_frame_sender
    import sender_pkg::*;
#(
    parameter int unsigned DATA_W     = 40,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned BIT_DIV    = 1,
    parameter int unsigned GAP_BITS   = 1,
    parameter int unsigned MSB_FIRST  = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_frame_sender_if.slave bus
);
`ifdef SENDER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int unsigned FRAME_BITS = frame_bits(DATA_W, PARITY_EN);
    localparam int unsigned CNT_MAX    = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_W      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, frame_word;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sout_q, sout_d, done_q, done_d;
    logic                  load, next_frame;
    logic [DATA_W-1:0]     fifo_rdata, data_ord;
    logic                  fifo_full, fifo_empty;

    sender_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (bus.in_valid),
        .wdata_i (bus.in_data),
        .pop_i   (load),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The shifter always emits its MSB, so LSB-first order is a bit reversal at load.
    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            data_ord[i] = (MSB_FIRST != 0) ? fifo_rdata[i] : fifo_rdata[DATA_W-1-i];
        end
    end

`ifdef SENDER_PARITY_EN
    assign frame_word = {START_BIT, data_ord, ^fifo_rdata};
`else
    assign frame_word = {START_BIT, data_ord};
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        sout_d     = sout_q;
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        next_frame = 1'b0;
        load       = 1'b0;
        case (state_q)
            StIdle: begin
                div_d = '0;
                load  = !fifo_empty;
            end
            StShift: begin
                if (div_q == DIV_LAST) begin
                    if (cnt_q == BIT_LAST) begin
                        done_d = 1'b1;
                        if (GAP_BITS > 0) begin
                            state_d = StGap;
                            cnt_d   = '0;
                            sout_d  = IDLE_LEVEL;
                            shift_d = '0;
                        end else begin
                            next_frame = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                        sout_d  = shift_q[FRAME_BITS-2];
                    end
                end
            end
            StGap: begin
                if (div_q == DIV_LAST) begin
                    if (cnt_q == GAP_LAST) next_frame = 1'b1;
                    else                   cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (next_frame) begin
            load = !fifo_empty;
            if (fifo_empty) begin
                state_d = StIdle;
                sout_d  = IDLE_LEVEL;
                shift_d = '0;
            end
        end

        // Every load restarts the divider so each frame begins phase-aligned.
        if (load) begin
            state_d = StShift;
            shift_d = frame_word;
            sout_d  = START_BIT;
            div_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            sout_q  <= IDLE_LEVEL;
            div_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            sout_q  <= sout_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.sout       = sout_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = (state_q != StIdle) || !fifo_empty;

endmodule
